// File: rtl/sample_arb_pkg.sv
// Shared types and constants for the sample arbiter and related
// multi-requester blocks.
package sample_arb_pkg;

  // Arbiter FSM states; encodings are fixed so waveforms read consistently.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Width of the tenure counter; also bounds the legal MAX_HOLD range.
  localparam int CNT_W = 8;

endpackage : sample_arb_pkg

// File: rtl/sample_arbiter_rr_pick.sv
// Combinational rotating-priority select: returns the first set request
// bit found scanning from ptr upward, wrapping modulo N.
module rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] win,
  output logic           any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      // Explicit wrap: N need not be a power of two.
      if (idx >= N) idx = idx - N;
      if (!any && req[idx[IDW-1:0]]) begin
        any = 1'b1;
        win = idx[IDW-1:0];
      end
    end
  end

endmodule : rr_pick

// File: rtl/sample_arbiter.sv
// Round-robin owner of a single shared 1-bit sampler. The granted
// requester's data bit is registered every cycle and a one-cycle pulse
// marks every toggle of the sampled value.
module sample_arbiter
  import sample_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   data_in,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] owner,
  output logic           busy,
  output logic           sample,
  output logic           data_o
);

  // Last counter value of a tenure; reaching it forces a release.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state;
  logic [IDW-1:0]   ptr;
  logic [CNT_W-1:0] cnt;
  logic             sample_prev;
  logic [IDW-1:0]   win;
  logic             any;
  logic             owner_bit;
  logic             tenure_end;

  rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // Owner's data bit and the end-of-tenure condition for the current cycle.
  assign owner_bit  = data_in[owner];
  assign tenure_end = !req[owner] || (cnt == CNT_LAST);

  // Arbitration FSM, tenure counter and sampling datapath in one register block.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      owner       <= '0;
      busy        <= 1'b0;
      sample      <= 1'b0;
      sample_prev <= 1'b0;
      data_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state <= GRANT;
            grant <= {{(N-1){1'b0}}, 1'b1} << win;
            owner <= win;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end

        GRANT: begin
          // The cycle that ends a tenure still samples the owner's bit.
          sample      <= owner_bit;
          sample_prev <= sample;
          data_o      <= owner_bit ^ sample;
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
          if (tenure_end) begin
            state <= RELEASE;
            grant <= '0;
            busy  <= 1'b0;
          end
        end

        RELEASE: begin
          // Last owner becomes lowest priority for the next scan.
          ptr         <= (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;
          sample      <= 1'b0;
          sample_prev <= 1'b0;
          data_o      <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the datapath and grant vector.
  assert property (@(posedge clk) $onehot0(grant));
  assert property (@(posedge clk) data_o == (sample ^ sample_prev));

endmodule : sample_arbiter

// File: tb/tb_sample_arbiter.sv
// Directed self-checking bench for sample_arbiter (N=4, MAX_HOLD=8).
module tb_sample_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] data_in;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       sample;
  logic       data_o;

  int total  = 0;
  int passed = 0;

  sample_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data_in (data_in),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .sample  (sample),
    .data_o  (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; data_in = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; data_in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (grant !== 4'b0000 || busy !== 1'b0 || data_o !== 1'b0)
        $display("FAIL reset_hold[%0d]: grant=%b busy=%b data_o=%b want 0000/0/0", i, grant, busy, data_o);
      else passed++;
    end
    total++;
    if (owner !== 2'd0 || sample !== 1'b0)
      $display("FAIL reset_owner_sample: owner=%0d sample=%b want 0/0", owner, sample);
    else passed++;
    rst = 1'b0; req = 4'b0000; data_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (grant !== 4'b0000 || busy !== 1'b0)
        $display("FAIL idle_hold[%0d]: grant=%b busy=%b want 0000/0", i, grant, busy);
      else passed++;
    end
  endtask

  task automatic test_single_hold();
    int busy_cnt;
    int pulses;
    do_reset();
    req = 4'b0100; data_in = 4'b0100;
    step();
    total++;
    if (grant !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1)
      $display("FAIL single_grant: grant=%b owner=%0d busy=%b want 0100/2/1", grant, owner, busy);
    else passed++;
    busy_cnt = 1;
    pulses   = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (busy === 1'b1) busy_cnt++;
      if (data_o === 1'b1) pulses++;
      if (i == 0) begin
        total++;
        if (data_o !== 1'b1)
          $display("FAIL single_first_pulse: data_o=%b want 1", data_o);
        else passed++;
      end
    end
    total++;
    if (busy_cnt !== 8)
      $display("FAIL single_busy_len: got %0d want 8", busy_cnt);
    else passed++;
    total++;
    if (pulses !== 1)
      $display("FAIL single_pulse_count: got %0d want 1", pulses);
    else passed++;
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0)
      $display("FAIL single_release: grant=%b busy=%b want 0000/0", grant, busy);
    else passed++;
    step();
    total++;
    if (busy !== 1'b0)
      $display("FAIL single_gap_idle: busy=%b want 0", busy);
    else passed++;
    step();
    total++;
    if (grant !== 4'b0100 || owner !== 2'd2)
      $display("FAIL single_regrant: grant=%b owner=%0d want 0100/2", grant, owner);
    else passed++;
    req = 4'b0000; data_in = 4'b0000;
    step(); step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    int held;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step();
      total++;
      if (grant !== exp_g || owner !== 2'(k % 4) || busy !== 1'b1)
        $display("FAIL rr_owner[%0d]: grant=%b owner=%0d want %b/%0d", k, grant, owner, exp_g, k % 4);
      else passed++;
      held = 0;
      for (int i = 0; i < 7; i++) begin
        step();
        if (busy === 1'b1 && grant === exp_g) held++;
      end
      total++;
      if (held !== 7)
        $display("FAIL rr_tenure[%0d]: held %0d extra cycles want 7", k, held);
      else passed++;
      step();
      step();
      total++;
      if (busy !== 1'b0 || grant !== 4'b0000)
        $display("FAIL rr_gap[%0d]: busy=%b grant=%b want 0/0000", k, busy, grant);
      else passed++;
    end
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_early_drop();
    do_reset();
    req = 4'b0010;
    step();
    total++;
    if (owner !== 2'd1 || grant !== 4'b0010)
      $display("FAIL drop_grant: owner=%0d grant=%b want 1/0010", owner, grant);
    else passed++;
    req = 4'b1011;
    step(); step();
    total++;
    if (grant !== 4'b0010)
      $display("FAIL drop_no_preempt: grant=%b want 0010", grant);
    else passed++;
    req = 4'b1001;
    step();
    total++;
    if (busy !== 1'b0 || grant !== 4'b0000)
      $display("FAIL drop_release: busy=%b grant=%b want 0/0000", busy, grant);
    else passed++;
    step(); step();
    total++;
    if (owner !== 2'd3 || grant !== 4'b1000)
      $display("FAIL drop_next_owner: owner=%0d grant=%b want 3/1000", owner, grant);
    else passed++;
    req = 4'b0001;
    step(); step(); step();
    total++;
    if (owner !== 2'd0 || grant !== 4'b0001)
      $display("FAIL ptr_wrap: owner=%0d grant=%b want 0/0001", owner, grant);
    else passed++;
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_edge_detect();
    logic [4:0] pat;
    logic [4:0] exp_d;
    logic [2:0] other;
    pat   = 5'b10110;  // bit i is applied in data cycle i: 0,1,1,0,1
    exp_d = 5'b11010;  // 0,1,0,1,1
    do_reset();
    req = 4'b0001;
    step();
    for (int i = 0; i < 5; i++) begin
      other = (i % 2 == 1) ? 3'b111 : 3'b000;
      data_in = {other, pat[i]};
      step();
      total++;
      if (sample !== pat[i] || data_o !== exp_d[i])
        $display("FAIL edge[%0d]: sample=%b data_o=%b want %b/%b", i, sample, data_o, pat[i], exp_d[i]);
      else passed++;
    end
    req = 4'b0000; data_in = 4'b1110;
    step();
    total++;
    if (busy !== 1'b0 || sample !== 1'b0 || data_o !== 1'b1)
      $display("FAIL edge_last_sample: busy=%b sample=%b data_o=%b want 0/0/1", busy, sample, data_o);
    else passed++;
    step();
    total++;
    if (sample !== 1'b0 || data_o !== 1'b0)
      $display("FAIL edge_release_clear: sample=%b data_o=%b want 0/0", sample, data_o);
    else passed++;
    data_in = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_and_simul();
    do_reset();
    req = 4'b1000; data_in = 4'b1000;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (owner !== 2'd3 || sample !== 1'b1)
      $display("FAIL mid_pre: owner=%0d sample=%b want 3/1", owner, sample);
    else passed++;
    rst = 1'b1; req = 4'b1001;
    step();
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0 || sample !== 1'b0 || owner !== 2'd0)
      $display("FAIL mid_reset: grant=%b busy=%b sample=%b owner=%0d want 0000/0/0/0", grant, busy, sample, owner);
    else passed++;
    rst = 1'b0;
    step();
    total++;
    if (grant !== 4'b0001 || owner !== 2'd0)
      $display("FAIL mid_rescan: grant=%b owner=%0d want 0001/0", grant, owner);
    else passed++;

    do_reset();
    req = 4'b0100; data_in = 4'b0000;
    for (int i = 0; i < 8; i++) step();
    req = 4'b0000;
    step();
    total++;
    if (busy !== 1'b0 || grant !== 4'b0000)
      $display("FAIL simul_release: busy=%b grant=%b want 0/0000", busy, grant);
    else passed++;
    req = 4'b0101;
    step(); step();
    total++;
    if (grant !== 4'b0001 || owner !== 2'd0)
      $display("FAIL simul_single_release: grant=%b owner=%0d want 0001/0", grant, owner);
    else passed++;
    req = 4'b0000;
    step(); step();
  endtask

  initial begin
    rst = 1'b1; req = '0; data_in = '0;
    test_reset();
    test_single_hold();
    test_round_robin();
    test_early_drop();
    test_edge_detect();
    test_reset_mid_and_simul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_sample_arbiter

// File: doc/sample_arbiter.md
Name: sample_arbiter

Overview:
- Round-robin arbiter that shares one registered 1-bit sampling datapath among N requesters.
- Grants the sampler to one requester at a time and samples that requester's data bit every cycle.
- Emits a change-detect pulse on each toggle of the sampled bit (sample XOR previous sample).
- Sits between the per-channel input stages and the single shared sampler/edge-detect stage.

Parameters:
- N, 4, number of requesters (legal range 2..16).
- MAX_HOLD, 8, maximum consecutive GRANT cycles per tenure (legal range 1..255).
- IDW, $clog2(N), localparam; width of the owner index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request; level-held for the whole tenure.
- data_in  in  N  per-requester data bit.
- grant  out  N  one-hot grant, registered.
- owner  out  IDW  index of the current owner; valid only while busy=1.
- busy  out  1  high in GRANT state.
- sample  out  1  registered sample of data_in[owner].
- data_o  out  1  change pulse: sample XOR sample_prev, registered.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (rst sampled on rising clk). On reset:
  - state=IDLE, ptr=0, cnt=0;
  - grant=0, owner=0, busy=0, sample=0, sample_prev=0, data_o=0.
- Reset mid-tenure drops grant on the next edge with no RELEASE cycle, and ptr returns to 0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ..., wrapping mod N.
  - Next cycle: state=GRANT, grant=onehot(win), owner=win, busy=1, cnt=0.
  - Arbitration latency from req asserted to grant is exactly 1 cycle.
- GRANT, every cycle:
  - sample<=data_in[owner], sample_prev<=sample, data_o<=data_in[owner]^sample.
  - cnt<=cnt+1, saturating at MAX_HOLD-1.
- Tenure end:
  - Condition: req[owner]==0, or cnt==MAX_HOLD-1.
  - Next state=RELEASE; grant=0 and busy=0 from that edge.
  - If both conditions hold in the same cycle, a single RELEASE occurs.
  - The cycle in which req[owner] is seen low still samples data_in[owner].
- RELEASE (exactly 1 cycle):
  - ptr<=(owner+1) mod N; wrap from N-1 to 0.
  - sample_prev<=0, sample<=0, data_o<=0; then IDLE.
  - Requests are not evaluated in RELEASE. Minimum gap between tenures is 2 cycles (RELEASE + IDLE arbitration).
- Fairness:
  - The last owner has lowest priority next round.
  - A continuously requesting agent is re-granted within N tenures.
- Requests from non-owners during GRANT are ignored (no queuing); they are evaluated at the next IDLE.
- data_in of non-owners never affects outputs.
- data_o in the first GRANT cycle compares against sample=0, so a leading 1 produces a pulse.
- grant is always one-hot or zero; it must never be multi-hot.
- owner holds its last value outside GRANT.
- Width rules:
  - cnt is 8 bits, unsigned.
  - ptr and owner are IDW bits; mod-N wrap is explicit, since N may be a non-power-of-2.

Decomposition:
- Shared package sample_arb_pkg: state enum (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2) and the MAX_HOLD width constant (8).
- One natural sub-module, rr_pick: combinational rotate-priority-select (req, ptr -> win, any).
  - Reusable by future multi-requester blocks.
- FSM, counter and sampling datapath stay in the top.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with req=4'b1111 -> grant=0, busy=0, data_o=0 throughout. After release with req=0 -> IDLE held.
- Single requester, hold limit: req=4'b0100, data_in[2] constant 1, MAX_HOLD=8:
  - grant=4'b0100 one cycle after req, owner=2, busy high 8 cycles;
  - data_o=1 only in the first GRANT cycle;
  - then one RELEASE cycle, then re-grant to agent 2 two cycles later.
- Round-robin rotation: req=4'b1111 held -> owners in order 0,1,2,3,0, each tenure 8 GRANT cycles, separated by 2-cycle gaps.
- Early drop: agent 1 granted, req[1] dropped at GRANT cycle 3 -> RELEASE on the following edge. Next IDLE scan starts at index 2: with req=4'b1001 pending -> owner=3.
- Edge detect: owner drives data_in pattern 0,1,1,0,1 -> sample follows 1 cycle later; data_o=1,0,1,1 on the cycles after each toggle; agents other than owner toggling -> no effect.
- Reset mid-tenure, plus simultaneous end conditions:
  - rst pulsed in GRANT cycle 4 of agent 3 -> grant=0 next edge, next winner scans from 0.
  - req drop coinciding with cnt=MAX_HOLD-1 -> exactly one RELEASE cycle.
